// File: rtl/auth_pkg.sv
// auth_pkg: shared types and constants for the key-check initiator.
// FSM state encoding, failure-counter width and the MAX_FAILS legality helper.
package auth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_LOCKOUT = 2'd2
  } auth_state_e;

  localparam int FAIL_CNT_W   = 4;
  localparam int FAIL_CNT_MAX = (1 << FAIL_CNT_W) - 1;

  localparam int MAX_FAILS_LO = 1;
  localparam int MAX_FAILS_HI = FAIL_CNT_MAX;

  // Pull an out-of-range MAX_FAILS back into 1..15 so that lockout stays
  // reachable with a saturating 4-bit counter.
  function automatic int legal_max_fails(input int m);
    if (m < MAX_FAILS_LO) return MAX_FAILS_LO;
    if (m > MAX_FAILS_HI) return MAX_FAILS_HI;
    return m;
  endfunction

endpackage

// File: rtl/auth_lock_timer.sv
// auth_lock_timer: loadable down-counter timing the lockout window.
// load presets LOCK_CYCLES-1; dec counts down and stops at zero; expired flags zero.
module auth_lock_timer
  import auth_pkg::*;
#(
  parameter int LOCK_CYCLES = 1000,
  localparam int TW = $clog2(LOCK_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [TW-1:0] cnt,
  output logic          expired
);

  localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: load wins over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/auth_attempt_ctrl.sv
// auth_attempt_ctrl: accepts candidate keys from the host, runs one compare at a
// time against the key comparator, pulses grant/deny, counts consecutive failures
// and enforces a timed lockout with a sticky interrupt.
// Optional build macro AUTH_TIMEOUT_EN: a compare with no cmp_done within
// TIMEOUT_CYCLES is abandoned and counted as a miss.
module auth_attempt_ctrl
  import auth_pkg::*;
#(
  parameter int KEY_W          = 32,
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [KEY_W-1:0]      key_data,
  output logic                  key_ready,
  output logic                  cmp_req,
  output logic [KEY_W-1:0]      cmp_key,
  input  logic                  cmp_done,
  input  logic                  cmp_match,
  output logic                  grant,
  output logic                  deny,
  output logic                  locked,
  output logic                  irq,
  input  logic                  irq_ack,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam int TW = $clog2(LOCK_CYCLES);
  localparam logic [FAIL_CNT_W-1:0] MAX_FAILS_V  = FAIL_CNT_W'(legal_max_fails(MAX_FAILS));
  localparam logic [FAIL_CNT_W-1:0] FAIL_SAT_V   = FAIL_CNT_W'(FAIL_CNT_MAX);

  auth_state_e           state_q, state_d;
  logic                  key_ready_q, key_ready_d;
  logic                  cmp_req_q, cmp_req_d;
  logic [KEY_W-1:0]      cmp_key_q, cmp_key_d;
  logic                  grant_q, grant_d;
  logic                  deny_q, deny_d;
  logic                  locked_q, locked_d;
  logic                  irq_q, irq_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic                  irq_set;
  logic                  tmr_load;
  logic                  tmr_dec;
  logic                  tmr_expired;
  logic [TW-1:0]         tmr_cnt;
  logic                  timeout_hit;
  logic [FAIL_CNT_W-1:0] fail_inc;

  auth_lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .cnt     (tmr_cnt),
    .expired (tmr_expired)
  );

`ifdef AUTH_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  // Count cycles spent in COMPARE; the count restarts from zero on every entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_COMPARE) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Compare-timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_COMPARE) && (to_cnt_q == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  logic unused_tmr_cnt;
  assign unused_tmr_cnt = ^tmr_cnt;

  // Saturating increment used when a compare ends in a miss.
  assign fail_inc = (fail_cnt_q == FAIL_SAT_V) ? FAIL_SAT_V : fail_cnt_q + 1'b1;

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    key_ready_d = 1'b0;
    cmp_req_d   = cmp_req_q;
    cmp_key_d   = cmp_key_q;
    grant_d     = 1'b0;
    deny_d      = 1'b0;
    locked_d    = locked_q;
    fail_cnt_d  = fail_cnt_q;
    irq_set     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        key_ready_d = 1'b1;
        if (key_valid && key_ready_q) begin
          cmp_key_d   = key_data;
          cmp_req_d   = 1'b1;
          key_ready_d = 1'b0;
          state_d     = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        // A real result on the expiry cycle takes priority over the timeout.
        if (cmp_done && cmp_match) begin
          cmp_req_d   = 1'b0;
          grant_d     = 1'b1;
          fail_cnt_d  = '0;
          key_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (cmp_done || timeout_hit) begin
          cmp_req_d  = 1'b0;
          deny_d     = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc >= MAX_FAILS_V) begin
            locked_d = 1'b1;
            irq_set  = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_LOCKOUT;
          end else begin
            key_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_LOCKOUT: begin
        // Timer was preset to LOCK_CYCLES-1, so locked spans exactly LOCK_CYCLES cycles.
        if (tmr_expired) begin
          locked_d    = 1'b0;
          fail_cnt_d  = '0;
          key_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky interrupt: a new lockout beats a coincident acknowledge.
  always_comb begin
    irq_d = irq_set | (irq_q & ~irq_ack);
  end

  // State and output registers; reset aborts any compare or lockout in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_ready_q <= 1'b0;
      cmp_req_q   <= 1'b0;
      cmp_key_q   <= '0;
      grant_q     <= 1'b0;
      deny_q      <= 1'b0;
      locked_q    <= 1'b0;
      irq_q       <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      cmp_req_q   <= cmp_req_d;
      cmp_key_q   <= cmp_key_d;
      grant_q     <= grant_d;
      deny_q      <= deny_d;
      locked_q    <= locked_d;
      irq_q       <= irq_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign key_ready = key_ready_q;
  assign cmp_req   = cmp_req_q;
  assign cmp_key   = cmp_key_q;
  assign grant     = grant_q;
  assign deny      = deny_q;
  assign locked    = locked_q;
  assign irq       = irq_q;
  assign fail_cnt  = fail_cnt_q;

endmodule
